alu_operand_sequencer: RTL and testbench

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_operand_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle ALU sequencer: reads two operands from an external register file,
// executes one op and writes the result back. Define ALU_SEQ_MUL_EN to add opcode 10 (MUL).
module alu_operand_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [3:0]  cmd_srcA,
   input  logic [3:0]  cmd_srcB,
   input  logic [3:0]  cmd_dst,
   output logic        rf_re,
   output logic [3:0]  rf_rAddr,
   input  logic [31:0] rf_rData,
   output logic        rf_we,
   output logic [3:0]  rf_wAddr,
   output logic [31:0] rf_wData,
   output logic        done,
   output logic        err,
   output logic [31:0] result,
   output logic        flag_z,
   output logic        flag_c
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_A  = 3'd1,
      S_RD_B  = 3'd2,
      S_CAP_B = 3'd3,
      S_EXEC  = 3'd4,
      S_WB    = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, srcA_q, srcB_q, dst_q;
   logic [31:0] opA_q, opB_q, result_q;
   logic        z_q, c_q, ill_q;

   logic [31:0] res_d;
   logic        c_d, ill_d;
   logic [32:0] sum;
`ifdef ALU_SEQ_MUL_EN
   logic [63:0] prod;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cmd_valid) state_d = S_RD_A;
         S_RD_A:  state_d = S_RD_B;
         S_RD_B:  state_d = S_CAP_B;
         S_CAP_B: state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Read data lags the read request by one cycle, so A lands during RD_B and B during CAP_B.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= '0;
         srcA_q   <= '0;
         srcB_q   <= '0;
         dst_q    <= '0;
         opA_q    <= '0;
         opB_q    <= '0;
         result_q <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         if (state_q == S_IDLE && cmd_valid) begin
            op_q   <= cmd_op;
            srcA_q <= cmd_srcA;
            srcB_q <= cmd_srcB;
            dst_q  <= cmd_dst;
         end
         if (state_q == S_RD_B)  opA_q <= rf_rData;
         if (state_q == S_CAP_B) opB_q <= rf_rData;
         if (state_q == S_EXEC) begin
            result_q <= res_d;
            z_q      <= (res_d == 32'd0);
            c_q      <= c_d;
            ill_q    <= ill_d;
         end
      end
   end

   assign sum = {1'b0, opA_q} + {1'b0, opB_q};
`ifdef ALU_SEQ_MUL_EN
   assign prod = {32'd0, opA_q} * {32'd0, opB_q};
`endif

   always_comb begin
      res_d = 32'd0;
      c_d   = 1'b0;
      ill_d = 1'b0;
      case (op_q)
         4'd0: begin res_d = sum[31:0]; c_d = sum[32]; end
         4'd1: begin res_d = opA_q - opB_q; c_d = (opA_q < opB_q); end
         4'd2: res_d = opA_q & opB_q;
         4'd3: res_d = opA_q | opB_q;
         4'd4: res_d = opA_q ^ opB_q;
         4'd5: res_d = ~opA_q;
         4'd6: res_d = opA_q << opB_q[4:0];
         4'd7: res_d = opA_q >> opB_q[4:0];
         4'd8: res_d = $unsigned($signed(opA_q) >>> opB_q[4:0]);
         4'd9: res_d = opA_q;
`ifdef ALU_SEQ_MUL_EN
         4'd10: begin res_d = prod[31:0]; c_d = (prod[63:32] != 32'd0); end
`endif
         default: ill_d = 1'b1;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      rf_re     = (state_q == S_RD_A) || (state_q == S_RD_B);
      rf_rAddr  = 4'd0;
      if (state_q == S_RD_A) rf_rAddr = srcA_q;
      if (state_q == S_RD_B) rf_rAddr = srcB_q;
      done      = (state_q == S_WB);
      err       = (state_q == S_WB) && ill_q;
      rf_we     = (state_q == S_WB) && !ill_q;
      rf_wAddr  = rf_we ? dst_q : 4'd0;
      rf_wData  = rf_we ? result_q : 32'd0;
      result    = result_q;
      flag_z    = z_q;
      flag_c    = c_q;
   end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized + directed bench for alu_operand_sequencer against a register-file
// reference model; honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_operand_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op, cmd_srcA, cmd_srcB, cmd_dst;
   logic        rf_re;
   logic [3:0]  rf_rAddr;
   logic [31:0] rf_rData;
   logic        rf_we;
   logic [3:0]  rf_wAddr;
   logic [31:0] rf_wData;
   logic        done, err;
   logic [31:0] result;
   logic        flag_z, flag_c;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] mdl [16];
   logic        mon_en = 1'b0;
   logic        stream = 1'b0;
   time         t_prev = 0;

   alu_operand_sequencer dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB), .cmd_dst(cmd_dst),
      .rf_re(rf_re), .rf_rAddr(rf_rAddr), .rf_rData(rf_rData),
      .rf_we(rf_we), .rf_wAddr(rf_wAddr), .rf_wData(rf_wData),
      .done(done), .err(err), .result(result), .flag_z(flag_z), .flag_c(flag_c)
   );

   always #5 clk = ~clk;

   // Register file read port: data appears the cycle after the request edge.
   always @(posedge clk) if (rf_re) rf_rData <= mdl[rf_rAddr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) if (mon_en) chk("re_we_excl", {31'd0, rf_re & rf_we}, 32'd0);

   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic z, output logic c,
                                   output logic ill);
      logic [32:0] s;
      logic [63:0] p;
      r = 0; c = 0; ill = 0;
      s = {1'b0, a} + {1'b0, b};
      p = {32'd0, a} * {32'd0, b};
      case (op)
         0: begin r = s[31:0]; c = s[32]; end
         1: begin r = a - b; c = (a < b); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = ~a;
         6: r = a << b[4:0];
         7: r = a >> b[4:0];
         8: r = $unsigned($signed(a) >>> b[4:0]);
         9: r = a;
`ifdef ALU_SEQ_MUL_EN
         10: begin r = p[31:0]; c = (p[63:32] != 0); end
`endif
         default: ill = 1;
      endcase
      z = (r == 0);
   endfunction

   task automatic run_cmd(input logic [3:0] op, input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] d, input logic keep);
      logic [31:0] r;
      logic z, c, ill;
      int w;
      w = 0;
      @(negedge clk);
      cmd_op = op; cmd_srcA = sa; cmd_srcB = sb; cmd_dst = d; cmd_valid = 1'b1;
      while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
      if (!cmd_ready) begin
         chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
         return;
      end
      ref_alu(op, mdl[sa], mdl[sb], r, z, c, ill);
      @(posedge clk);
      if (stream && t_prev != 0) chk("accept_spacing", 32'($time - t_prev), 32'd60);
      t_prev = $time;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) cmd_valid = keep;
         chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
         chk("rf_re", {31'd0, rf_re}, {31'd0, (k == 1 || k == 2)});
         if (k == 1) chk("rAddrA", {28'd0, rf_rAddr}, {28'd0, sa});
         if (k == 2) chk("rAddrB", {28'd0, rf_rAddr}, {28'd0, sb});
         if (k < 5) begin
            chk("done_early", {31'd0, done}, 32'd0);
            chk("we_early", {31'd0, rf_we}, 32'd0);
         end else begin
            chk("done", {31'd0, done}, 32'd1);
            chk("err", {31'd0, err}, {31'd0, ill});
            chk("we", {31'd0, rf_we}, {31'd0, !ill});
            if (!ill) begin
               chk("wAddr", {28'd0, rf_wAddr}, {28'd0, d});
               chk("wData", rf_wData, r);
               mdl[d] = r;
            end
            chk("result", result, r);
            chk("flag_z", {31'd0, flag_z}, {31'd0, z});
            chk("flag_c", {31'd0, flag_c}, {31'd0, c});
         end
      end
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0;
      cmd_op = 0; cmd_srcA = 0; cmd_srcB = 0; cmd_dst = 0;
      for (int i = 0; i < 16; i++) mdl[i] = $urandom;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_re_we_done_err", {28'd0, rf_re, rf_we, done, err}, 32'd0);
      chk("rst_addrs", {24'd0, rf_rAddr, rf_wAddr}, 32'd0);
      chk("rst_wData", rf_wData, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
      reset = 1'b0;
      mon_en = 1'b1;

      mdl[1] = 5; mdl[2] = 7;           run_cmd(0, 1, 2, 3, 0);
      chk("add_5_7", mdl[3], 32'd12);
      mdl[1] = 3; mdl[2] = 5;           run_cmd(1, 1, 2, 4, 0);
      chk("sub_3_5", mdl[4], 32'hFFFFFFFE);
      mdl[1] = 9; mdl[2] = 9;           run_cmd(1, 1, 2, 4, 0);
      mdl[1] = 32'hFFFFFFFF; mdl[2] = 1; run_cmd(0, 1, 2, 5, 0);
      mdl[1] = 32'h80000000; mdl[2] = 4; run_cmd(8, 1, 2, 6, 0);
      chk("sra", mdl[6], 32'hF8000000);
      run_cmd(15, 1, 2, 7, 0);
      run_cmd(10, 1, 2, 7, 0);
      mdl[3] = 21;                       run_cmd(0, 3, 3, 3, 0);
      chk("self_add", mdl[3], 32'd42);

      // Reset asserted while the block is in RD_B
      @(negedge clk);
      cmd_op = 0; cmd_srcA = 1; cmd_srcB = 2; cmd_dst = 9; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); cmd_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
      chk("abort_outs", {29'd0, rf_re, rf_we, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("abort_quiet", {30'd0, rf_we, done}, 32'd0);
      end
      mdl[1] = 100; mdl[2] = 1;          run_cmd(1, 1, 2, 9, 0);

      // Continuous cmd_valid: one acceptance every 6 cycles
      stream = 1'b1; t_prev = 0;
      for (int i = 0; i < 8; i++)
         run_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), i != 7);
      stream = 1'b0;

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) mdl[$urandom_range(0, 15)] = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h0;
         run_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 0);
      end

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
